div_arbiter: RTL and testbench
==============================

// Module: div_arbiter
// PURPOSE
//  Shares the single sequential divider between the Speed and Average_speed requesters.
//  Accepts level requests with operands, grants one at a time, launches the divider and waits for ready.
//  Returns the quotient to the owning requester with a done pulse.
//  Replaces ad-hoc select/enable sequencing; sits between the two speed blocks and the divider.
// PARAMETERS
//  WIDTH        16    operand/result width (dividend, divisor, quotient)
//  TIMEOUT_CYC  64    max cycles in WAIT before abort; counter width $clog2(TIMEOUT_CYC+1)
// PORTS
//  clock         in   1      system clock, all logic on rising edge
//  reset         in   1      synchronous, active-high
//  spd_req       in   1      speed request, level; held until spd_ack
//  spd_dividend  in   WIDTH  speed dividend, valid while spd_req=1
//  spd_divisor   in   WIDTH  speed divisor, valid while spd_req=1
//  spd_ack       out  1      1-cycle pulse: speed operands latched
//  spd_done      out  1      1-cycle pulse: res_out holds speed result
//  avg_req       in   1      avg-speed request, level; held until avg_ack
//  avg_dividend  in   WIDTH  avg-speed dividend
//  avg_divisor   in   WIDTH  avg-speed divisor
//  avg_ack       out  1      1-cycle pulse: avg operands latched
//  avg_done      out  1      1-cycle pulse: res_out holds avg result
//  res_out       out  WIDTH  last quotient; stable from done until next done
//  dz_flag       out  1      high with done when divisor was 0
//  timeout_err   out  1      sticky: divider never returned ready; cleared only by reset
//  arb_busy      out  1      high whenever state != IDLE
//  div_start     out  1      1-cycle launch pulse to divider
//  div_select    out  1      0=speed, 1=avg; held stable LAUNCH..DONE
//  div_dividend  out  WIDTH  latched dividend to divider
//  div_divisor   out  WIDTH  latched divisor to divider
//  div_busy      in   1      divider computing
//  div_ready     in   1      1-cycle pulse: div_res valid
//  div_res       in   WIDTH  divider quotient
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, last_grant=avg (speed wins first tie), timeout counter 0.
//  FSM: IDLE -> LAUNCH -> WAIT -> DONE -> IDLE; DZ path: IDLE -> DONE.
//  IDLE: if any req, pick owner; both pending -> owner = requester not in last_grant.
//   Latch operands, div_select=owner, last_grant=owner; owner's ack pulses next cycle.
//   Latched divisor==0 -> DONE directly (no div_start); else -> LAUNCH.
//  LAUNCH (1 cycle): div_start=1, ack pulse; clear timeout counter; -> WAIT.
//  WAIT: on div_ready capture div_res into res_out -> DONE.
//   Counter increments each WAIT cycle; reaching TIMEOUT_CYC without ready:
//   res_out={WIDTH{1}}, timeout_err=1 -> DONE.
//  DONE (1 cycle): owner's done=1; dz_flag=1 iff DZ path (res_out={WIDTH{1}} on DZ).
//   -> IDLE. A req still high in IDLE is a new request.
//   No grant to the other requester in the DONE cycle.
//  Latency: req sampled in IDLE cycle T; ack at T+1 (with div_start);
//   ready at cycle R -> done at R+1; DZ: ack and done both at T+1.
//  div_ready outside WAIT is ignored; div_busy is informational only (no state effect).
//  Requests arriving while not IDLE stay pending (level) and are served after DONE.
//  Only one of spd_ack/avg_ack/spd_done/avg_done is high in any cycle.
//  Reset mid-operation: next cycle IDLE, all outputs 0, no done for aborted job.
//  No arithmetic beyond compare; operands passed through unmodified.
// TESTING
//  spd_req, 1000/40, divider ready 17 cycles after start -> spd_ack at T+1, div_select=0, spd_done with res_out=25.
//  spd_req and avg_req same cycle -> speed served first; avg served next; then both again -> order alternates.
//  avg_req, divisor=0 -> avg_ack and avg_done at T+1, dz_flag=1, res_out=16'hFFFF, div_start never high.
//  Divider model never asserts ready -> after 64 WAIT cycles done pulses, res_out=16'hFFFF, timeout_err stays 1.
//  reset during WAIT -> next cycle IDLE, all outputs 0; later request completes normally.
//  Spurious div_ready in IDLE and a req held after done -> ready ignored; held req re-granted as new job.

Source files
------------

// File: rtl/div_arbiter.sv
// div_arbiter: shares one sequential divider between the speed and average-speed requesters,
// with divide-by-zero short-circuit and a watchdog on the divider's ready pulse.
module div_arbiter #(
    parameter int WIDTH       = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             spd_req,
    input  logic [WIDTH-1:0] spd_dividend,
    input  logic [WIDTH-1:0] spd_divisor,
    output logic             spd_ack,
    output logic             spd_done,
    input  logic             avg_req,
    input  logic [WIDTH-1:0] avg_dividend,
    input  logic [WIDTH-1:0] avg_divisor,
    output logic             avg_ack,
    output logic             avg_done,
    output logic [WIDTH-1:0] res_out,
    output logic             dz_flag,
    output logic             timeout_err,
    output logic             arb_busy,
    output logic             div_start,
    output logic             div_select,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_busy,
    input  logic             div_ready,
    input  logic [WIDTH-1:0] div_res
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

    state_t           state;
    logic             last_grant;
    logic [CW-1:0]    cnt;
    logic             owner;
    logic [WIDTH-1:0] sel_dividend;
    logic [WIDTH-1:0] sel_divisor;
    logic             unused_busy;

    // On a tie the requester that did not win last time gets the divider
    assign owner        = (spd_req && avg_req) ? ~last_grant : avg_req;
    assign sel_dividend = owner ? avg_dividend : spd_dividend;
    assign sel_divisor  = owner ? avg_divisor : spd_divisor;
    assign unused_busy  = div_busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            cnt          <= '0;
            spd_ack      <= 1'b0;
            spd_done     <= 1'b0;
            avg_ack      <= 1'b0;
            avg_done     <= 1'b0;
            res_out      <= '0;
            dz_flag      <= 1'b0;
            timeout_err  <= 1'b0;
            arb_busy     <= 1'b0;
            div_start    <= 1'b0;
            div_select   <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            spd_ack   <= 1'b0;
            avg_ack   <= 1'b0;
            spd_done  <= 1'b0;
            avg_done  <= 1'b0;
            dz_flag   <= 1'b0;
            div_start <= 1'b0;
            case (state)
                IDLE: if (spd_req || avg_req) begin
                    div_select   <= owner;
                    last_grant   <= owner;
                    div_dividend <= sel_dividend;
                    div_divisor  <= sel_divisor;
                    spd_ack      <= ~owner;
                    avg_ack      <= owner;
                    arb_busy     <= 1'b1;
                    if (sel_divisor == '0) begin
                        state    <= DONE;
                        spd_done <= ~owner;
                        avg_done <= owner;
                        dz_flag  <= 1'b1;
                        res_out  <= '1;
                    end else begin
                        state     <= LAUNCH;
                        div_start <= 1'b1;
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: if (div_ready) begin
                    res_out  <= div_res;
                    spd_done <= ~div_select;
                    avg_done <= div_select;
                    state    <= DONE;
                end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                    res_out     <= '1;
                    timeout_err <= 1'b1;
                    spd_done    <= ~div_select;
                    avg_done    <= div_select;
                    state       <= DONE;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                DONE: begin
                    arb_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: random and directed jobs against a transaction-level model of the
// arbiter (grant order, latencies, quotients) with a latency-programmable divider model.
module tb_div_arbiter;
    localparam int W  = 16;
    localparam int TO = 64;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         spd_req = 1'b0, avg_req = 1'b0;
    logic [W-1:0] spd_dividend = '0, spd_divisor = '0, avg_dividend = '0, avg_divisor = '0;
    logic         spd_ack, spd_done, avg_ack, avg_done, dz_flag, timeout_err, arb_busy;
    logic         div_start, div_select, div_busy;
    logic         div_ready = 1'b0;
    logic [W-1:0] res_out, div_dividend, div_divisor;
    logic [W-1:0] div_res = '0;

    int  n_chk = 0, n_fail = 0, cyc = 0;
    int  lat = 5, lat_cnt = 0;
    bit  hang = 0, spur = 0, last_avg = 1;
    logic [W-1:0] q;

    div_arbiter #(.WIDTH(W), .TIMEOUT_CYC(TO)) dut (
        .clock(clock), .reset(reset),
        .spd_req(spd_req), .spd_dividend(spd_dividend), .spd_divisor(spd_divisor),
        .spd_ack(spd_ack), .spd_done(spd_done),
        .avg_req(avg_req), .avg_dividend(avg_dividend), .avg_divisor(avg_divisor),
        .avg_ack(avg_ack), .avg_done(avg_done),
        .res_out(res_out), .dz_flag(dz_flag), .timeout_err(timeout_err), .arb_busy(arb_busy),
        .div_start(div_start), .div_select(div_select),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_busy(div_busy), .div_ready(div_ready), .div_res(div_res)
    );

    always #5 clock = ~clock;

    assign div_busy = (lat_cnt != 0);

    // Divider: ready pulses lat cycles after the start pulse; hang suppresses it entirely
    initial forever begin
        @(posedge clock);
        #1;
        div_ready = 1'b0;
        if (spur) begin
            div_ready = 1'b1;
            div_res   = 16'h1234;
            spur      = 0;
        end else if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                div_ready = 1'b1;
                div_res   = q;
            end
        end
        if (div_start && !hang) begin
            lat_cnt = lat;
            q       = div_dividend / div_divisor;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
        cyc++;
    endtask

    function automatic logic [63:0] all_outs();
        return {spd_ack, spd_done, avg_ack, avg_done, res_out, dz_flag, timeout_err, arb_busy,
                div_start, div_select, div_dividend, div_divisor};
    endfunction

    task automatic wait_evt(input int which, output int c);
        logic [3:0] v;
        bit hit;
        hit = 0;
        c = -1;
        for (int k = 0; k < 200 && !hit; k++) begin
            step();
            v = {spd_ack, avg_ack, spd_done, avg_done};
            hit = v[3-which];
            if (hit) c = cyc;
        end
        if (!hit) check("evt_timeout", hit, 1);
    endtask

    // One or two concurrent requests, each checked against the expected grant order and timing
    task automatic do_job(input bit rs, input bit ra, input logic [W-1:0] sd, input logic [W-1:0] ss,
                          input logic [W-1:0] ad, input logic [W-1:0] as);
        bit ps, pa, act, own, edz;
        int g, dc;
        logic [W-1:0] edd, eds;
        logic [3:0] v;
        ps = rs; pa = ra; act = 0; own = 0; edz = 0; g = cyc; dc = 0; edd = '0; eds = '0;
        spd_req = rs; avg_req = ra;
        spd_dividend = sd; spd_divisor = ss; avg_dividend = ad; avg_divisor = as;
        for (int k = 0; k < 400 && (ps || pa || act); k++) begin
            step();
            v = {spd_ack, avg_ack, spd_done, avg_done};
            if (spd_ack || avg_ack) begin
                own = (ps && pa) ? !last_avg : pa;
                edd = own ? ad : sd;
                eds = own ? as : ss;
                edz = (eds == 0);
                check("ack_owner", avg_ack, own);
                check("ack_cycle", cyc, g + 1);
                check("div_select", div_select, own);
                check("div_operands", {div_dividend, div_divisor}, {edd, eds});
                check("div_start", div_start, !edz);
                check("busy_on_ack", arb_busy, 1);
                dc = edz ? cyc : cyc + (hang ? TO + 1 : lat + 1);
                last_avg = own;
                act = 1;
                if (avg_ack) begin pa = 0; avg_req = 0; end
                else begin ps = 0; spd_req = 0; end
            end
            if ($countones(v) > 1) check("pulse_excl", v, edz ? (own ? 4'b0101 : 4'b1010) : 4'b0);
            if (spd_done || avg_done) begin
                check("done_owner", avg_done, own);
                check("done_cycle", cyc, dc);
                check("res_out", res_out, (edz || hang) ? {W{1'b1}} : edd / eds);
                check("dz_flag", dz_flag, edz);
                check("select_held", div_select, own);
                act = 0;
                g = cyc + 1;
            end
        end
        check("job_complete", {ps, pa, act}, 0);
        spd_req = 0;
        avg_req = 0;
        step();
        check("idle_after_done", arb_busy, 0);
    endtask

    initial begin
        int c, a2, d1, d2;
        logic [W+2:0] seen;
        repeat (3) step();
        check("reset_outs", all_outs(), 0);
        reset = 0;
        step();
        lat = 5;
        do_job(1, 1, 16'd900, 16'd30, 16'd500, 16'd7);
        lat = 17;
        do_job(1, 0, 16'd1000, 16'd40, 16'd0, 16'd0);
        lat = 3;
        do_job(1, 1, 16'd65535, 16'd255, 16'd12, 16'd5);
        do_job(1, 1, 16'd81, 16'd9, 16'd4000, 16'd1);
        do_job(0, 1, 16'd0, 16'd0, 16'd300, 16'd0);
        do_job(1, 1, 16'd77, 16'd0, 16'd5, 16'd6);

        // Request held through done is served again as a fresh job
        spd_req = 1; spd_dividend = 16'd90; spd_divisor = 16'd9; lat = 3;
        wait_evt(0, c);
        wait_evt(2, d1);
        check("held_res1", res_out, 16'd10);
        wait_evt(0, a2);
        check("held_regrant_cycle", a2, d1 + 2);
        spd_req = 0;
        wait_evt(2, d2);
        check("held_res2", res_out, 16'd10);
        last_avg = 0;
        step();

        for (int i = 0; i < 30; i++) begin
            int m;
            m = $urandom_range(1, 3);
            lat = $urandom_range(1, 20);
            do_job(m[0], m[1], W'($urandom), ($urandom_range(0, 5) == 0) ? W'(0) : W'($urandom_range(1, 300)),
                   W'($urandom), ($urandom_range(0, 5) == 0) ? W'(0) : W'($urandom_range(1, 300)));
        end

        hang = 1;
        do_job(1, 0, 16'd77, 16'd7, 16'd0, 16'd0);
        check("timeout_err", timeout_err, 1);
        hang = 0;
        lat = 4;
        do_job(0, 1, 16'd0, 16'd0, 16'd100, 16'd3);
        check("timeout_sticky", timeout_err, 1);

        // Reset while waiting on the divider; its late ready and a stray one must be ignored
        lat = 40;
        spd_req = 1; spd_dividend = 16'd500; spd_divisor = 16'd5;
        wait_evt(0, c);
        spd_req = 0;
        repeat (5) step();
        reset = 1;
        step();
        check("rst_mid_outs", all_outs(), 0);
        reset = 0;
        last_avg = 1;
        spur = 1;
        seen = '0;
        repeat (45) begin
            step();
            seen |= {spd_done, avg_done, arb_busy, res_out};
        end
        check("stray_ready_ignored", seen, 0);
        lat = 6;
        do_job(1, 1, 16'd1200, 16'd11, 16'd999, 16'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
